// File: rtl/if_fetch.sv
// Byte-serial instruction fetch: assembles a 32-bit little-endian word from four
// byte reads and presents it to decode. Execute can redirect the pc at any time.
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stl_mm,
  input  logic        br_en,
  input  logic [31:0] br_tgt,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_dat,
  output logic [31:0] if_pc,
  output logic [31:0] if_is,
  output logic        not_ok
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= 32'd0;
      cnt_q   <= 2'd0;
      asm_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    mem_req  = 1'b0;
    not_ok   = 1'b1;
    mem_addr = pc_q + {30'd0, cnt_q};
    if_pc    = pc_q;
    if_is    = asm_q;

    if (state_q == FETCH) mem_req = !rst && !br_en;
    if (state_q == HOLD)  not_ok  = rst || br_en;

    // Redirect outranks both byte accept and consume, and ignores stall.
    if (br_en) begin
      pc_d    = br_tgt & 32'hFFFF_FFFC;
      cnt_d   = 2'd0;
      state_d = FETCH;
    end else if (state_q == FETCH) begin
      if (mem_rdy) begin
        asm_d[8*cnt_q +: 8] = mem_dat;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = HOLD;
      end
    end else if (!stl_mm) begin
      pc_d    = pc_q + 32'd4;
      state_d = FETCH;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: basic fetch, memory wait, stall, redirects,
// pc wrap and mid-fetch reset, against hand-computed words.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, stl_mm, br_en, mem_rdy;
  logic [31:0] br_tgt;
  logic        mem_req, not_ok;
  logic [31:0] mem_addr, if_pc, if_is;
  logic [7:0]  mem_dat;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .stl_mm(stl_mm), .br_en(br_en), .br_tgt(br_tgt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_dat(mem_dat),
    .if_pc(if_pc), .if_is(if_is), .not_ok(not_ok)
  );

  // Memory image: 0..3 hold 13 05 A0 00, everything else a[7:0]^a[15:8]^3C.
  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'hA0;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  assign mem_dat = mb(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stl_mm = 1'b0; br_en = 1'b0; br_tgt = 32'd0; mem_rdy = 1'b0;
    cyc(); cyc();
    smp();
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_nok", {31'd0, not_ok}, 32'd1);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_is", if_is, 32'd0);
    cyc();

    // Basic fetch
    rst = 1'b0; mem_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("bf_addr%0d", i), mem_addr, i);
      chk($sformatf("bf_req%0d", i), {31'd0, mem_req}, 32'd1);
      chk($sformatf("bf_nok%0d", i), {31'd0, not_ok}, 32'd1);
      cyc();
    end
    smp();
    chk("bf_hold_nok", {31'd0, not_ok}, 32'd0);
    chk("bf_hold_req", {31'd0, mem_req}, 32'd0);
    chk("bf_is", if_is, 32'h00A00513);
    chk("bf_pc", if_pc, 32'd0);
    cyc();
    smp();
    chk("bf_next_addr", mem_addr, 32'd4);

    // Memory wait on byte 2 of word at 4
    cyc(); cyc();
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk($sformatf("mw_addr%0d", i), mem_addr, 32'd6);
      chk($sformatf("mw_req%0d", i), {31'd0, mem_req}, 32'd1);
      chk($sformatf("mw_nok%0d", i), {31'd0, not_ok}, 32'd1);
      cyc();
    end
    mem_rdy = 1'b1;
    smp();
    chk("mw_addr_resume", mem_addr, 32'd6);
    cyc();
    smp();
    chk("mw_addr7", mem_addr, 32'd7);
    cyc();

    // Stall in HOLD
    stl_mm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("st_is%0d", i), if_is, 32'h3B3A3938);
      chk($sformatf("st_pc%0d", i), if_pc, 32'd4);
      chk($sformatf("st_nok%0d", i), {31'd0, not_ok}, 32'd0);
      cyc();
    end
    stl_mm = 1'b0;
    smp();
    chk("st_rel_nok", {31'd0, not_ok}, 32'd0);
    cyc();
    smp();
    chk("st_pc_adv", if_pc, 32'd8);
    chk("st_addr", mem_addr, 32'd8);

    // Redirect after byte 1
    cyc(); cyc();
    br_en = 1'b1; br_tgt = 32'h0000_0103;
    smp();
    chk("rd_nok", {31'd0, not_ok}, 32'd1);
    chk("rd_req", {31'd0, mem_req}, 32'd0);
    cyc();
    br_en = 1'b0;
    smp();
    chk("rd_addr", mem_addr, 32'h0000_0100);
    chk("rd_req2", {31'd0, mem_req}, 32'd1);
    cyc(); cyc(); cyc(); cyc();
    smp();
    chk("rd_is", if_is, 32'h3E3F3C3D);
    chk("rd_pc", if_pc, 32'h0000_0100);

    // Redirect during stalled HOLD, target near top of address space
    stl_mm = 1'b1; br_en = 1'b1; br_tgt = 32'hFFFF_FFFF;
    smp();
    chk("rh_nok", {31'd0, not_ok}, 32'd1);
    chk("rh_req", {31'd0, mem_req}, 32'd0);
    cyc();
    br_en = 1'b0; stl_mm = 1'b0;
    smp();
    chk("rh_nok2", {31'd0, not_ok}, 32'd1);
    chk("rh_pc", if_pc, 32'hFFFF_FFFC);
    chk("rh_addr", mem_addr, 32'hFFFF_FFFC);
    cyc(); cyc(); cyc();
    smp();
    chk("wr_addr3", mem_addr, 32'hFFFF_FFFF);
    cyc();
    smp();
    chk("wr_is", if_is, 32'h3C3D3E3F);
    chk("wr_nok", {31'd0, not_ok}, 32'd0);
    cyc();
    smp();
    chk("wr_pc", if_pc, 32'd0);
    chk("wr_addr", mem_addr, 32'd0);

    // Reset at byte 2
    cyc(); cyc();
    smp();
    chk("rs_addr2", mem_addr, 32'd2);
    rst = 1'b1;
    #1;
    chk("rs_req", {31'd0, mem_req}, 32'd0);
    chk("rs_nok", {31'd0, not_ok}, 32'd1);
    cyc();
    rst = 1'b0;
    smp();
    chk("rs_next_addr", mem_addr, 32'd0);
    chk("rs_is", if_is, 32'd0);
    chk("rs_pc", if_pc, 32'd0);
    chk("rs_req2", {31'd0, mem_req}, 32'd1);
    cyc(); cyc(); cyc(); cyc();
    smp();
    chk("rs_word", if_is, 32'h00A00513);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
